// File: rtl/uart_tx_serializer_if.sv
// Parallel-side bundle of the UART transmitter: request, payload, frame options and line status.
// The transmitter takes the slave modport; the requester takes the master modport.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] UartTx_P_DATA;
  logic                  UartTx_Data_Valid;
  logic                  UartTx_PAR_EN;
  logic                  UartTx_Par_Type;
  logic                  UartTx_TX_OUT;
  logic                  UartTx_Busy;

  modport master (
    output UartTx_P_DATA,
    output UartTx_Data_Valid,
    output UartTx_PAR_EN,
    output UartTx_Par_Type,
    input  UartTx_TX_OUT,
    input  UartTx_Busy
  );

  modport slave (
    input  UartTx_P_DATA,
    input  UartTx_Data_Valid,
    input  UartTx_PAR_EN,
    input  UartTx_Par_Type,
    output UartTx_TX_OUT,
    output UartTx_Busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start 0, data LSB first, optional parity, stop 1; one bit per clock.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  UartTx_CLK,
  input  logic                  UartTx_RST,
  uart_tx_serializer_if.slave   bus
);

  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  tx_q, tx_n;
  logic                  busy_q, busy_n;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_n;
  logic par_type_q, par_type_n;
  logic par_bit;

  assign par_bit = (^data_q) ^ par_type_q;
`else
  logic unused_cfg;

  assign unused_cfg = bus.UartTx_PAR_EN ^ bus.UartTx_Par_Type;
`endif

  always_ff @(posedge UartTx_CLK or negedge UartTx_RST) begin
    if (!UartTx_RST) begin
      state      <= IDLE;
      cnt        <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      data_q     <= data_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_n;
      par_type_q <= par_type_n;
`endif
    end
  end

  // Line and busy are registered, so each branch computes the values for the state being entered.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    data_n     = data_q;
    tx_n       = tx_q;
    busy_n     = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_n   = par_en_q;
    par_type_n = par_type_q;
`endif
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (bus.UartTx_Data_Valid) begin
          state_n    = START;
          data_n     = bus.UartTx_P_DATA;
          cnt_n      = '0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_en_n   = bus.UartTx_PAR_EN;
          par_type_n = bus.UartTx_Par_Type;
`endif
        end
      end
      START: begin
        state_n = DATA;
        tx_n    = data_q[0];
        busy_n  = 1'b1;
      end
      DATA: begin
        busy_n = 1'b1;
        if (cnt == LAST_BIT) begin
          cnt_n = '0;
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_n = PARITY;
            tx_n    = par_bit;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
`else
          state_n = STOP;
          tx_n    = 1'b1;
`endif
        end else begin
          cnt_n = cnt + CNT_W'(1);
          tx_n  = data_q[cnt_n];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        state_n = STOP;
        tx_n    = 1'b1;
        busy_n  = 1'b1;
      end
`endif
      STOP: begin
        // Always pass through IDLE so back-to-back requests get one idle-high cycle.
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.UartTx_TX_OUT = tx_q;
  assign bus.UartTx_Busy   = busy_q;

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have port UartTx_CLK, input, 1 bit: bit-rate clock; one serial bit per cycle; all state changes on its rising edge.
REQ-003 SHALL have port UartTx_RST, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port UartTx_P_DATA, input, DATA_WIDTH bits: parallel byte to send.
REQ-005 SHALL have port UartTx_Data_Valid, input, 1 bit: request to send UartTx_P_DATA.
REQ-006 SHALL have port UartTx_PAR_EN, input, 1 bit: 1 means append a parity bit.
REQ-007 SHALL have port UartTx_Par_Type, input, 1 bit: 0 means even parity, 1 means odd parity.
REQ-008 SHALL have port UartTx_TX_OUT, output, 1 bit: serial line, registered, idle high.
REQ-009 SHALL have port UartTx_Busy, output, 1 bit: registered, high while a frame is in flight.

Function
REQ-010 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL, in IDLE, drive TX_OUT=1 and Busy=0.
REQ-012 SHALL accept a request only at a rising edge with state=IDLE and Data_Valid=1, latching P_DATA, PAR_EN and Par_Type; from the edge after acceptance, TX_OUT=0 (start bit) and Busy=1.
REQ-013 SHALL ignore Data_Valid in every state other than IDLE; no buffering and no error flag.
REQ-014 SHALL, in DATA, output latched bits LSB first, one per cycle, using a bit counter of width clog2(DATA_WIDTH); leave DATA after bit DATA_WIDTH-1.
REQ-015 SHALL go DATA->PARITY when latched PAR_EN=1, else DATA->STOP.
REQ-016 SHALL send a parity bit equal to XOR of the latched data for even parity, and the inverse of that XOR for odd parity.
REQ-017 SHALL drive TX_OUT=1 for one cycle in STOP, then return to IDLE with Busy=0 on the following edge.
REQ-018 SHALL keep Busy=1 for exactly DATA_WIDTH+3 cycles per frame with parity, and DATA_WIDTH+2 cycles without parity.
REQ-019 SHALL provide at least one IDLE cycle between frames: Data_Valid held high gives one frame every DATA_WIDTH+4 cycles with parity, DATA_WIDTH+3 without.
REQ-020 SHALL not let changes to P_DATA, PAR_EN or Par_Type during a frame affect that frame.
REQ-021 SHALL produce frames bit-compatible with the team UART receiver: start 0, data LSB first, optional parity, stop 1.

Reset
REQ-022 SHALL, while UartTx_RST=0, immediately force state=IDLE, TX_OUT=1, Busy=0, bit counter=0 and the data latch to all zeros, with no dependence on the clock.
REQ-023 SHALL abandon any frame cut by a reset mid-frame; after reset release the line stays high until a new request is accepted.

Configuration
REQ-024 SHALL use macro UART_TX_PARITY_EN: when defined, the PARITY state and parity logic are compiled in and REQ-015/016 apply.
REQ-025 SHALL, when UART_TX_PARITY_EN is not defined, keep the PAR_EN and Par_Type ports but ignore them, remove the PARITY state, always go DATA->STOP, and use a frame length of DATA_WIDTH+2.

Verification
REQ-026 SHALL check: P_DATA=8'h55, PAR_EN=1, Par_Type=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,1,0,1,0,0,1; Busy high 11 cycles.
REQ-027 SHALL check: P_DATA=8'h55, PAR_EN=1, Par_Type=1 -> same sequence with parity bit 1; P_DATA=8'h01, even parity -> parity bit 1.
REQ-028 SHALL check: P_DATA=8'hA3, PAR_EN=0 -> sequence 0,1,1,0,0,0,1,0,1,1; Busy high 10 cycles.
REQ-029 SHALL check: Data_Valid held high with P_DATA toggling 8'h0F/8'hF0 -> each frame carries the value latched at acceptance; exactly one idle-high cycle between frames.
REQ-030 SHALL check: reset asserted during data bit 4 -> TX_OUT=1 and Busy=0 with no clock edge; the next request after release sends a complete, correct frame.
REQ-031 SHALL check loopback: feed uart_tx_serializer into the UART receiver (prescale 8, 16, 32, with the receiver clock at the matching multiple) -> received PDATA equals the sent value, with Data_Valid asserted, for parity even, odd and off.
